// File: rtl/ifu_pkg_ysyx23060136.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg_ysyx23060136;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RST_PC   = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_perf_cnt_ysyx23060136.sv
// Fetch and bubble event counters, 64-bit, cleared by rst, wrapping naturally.
// Zero latency: counts reflect events up to the previous rising edge; no backpressure.
module ifu_perf_cnt_ysyx23060136 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch,
    input  logic        i_bubble,
    output logic [63:0] o_fetch_cnt,
    output logic [63:0] o_bubble_cnt
);

    logic [63:0] r_fetch_cnt;
    logic [63:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 64'd0;
            r_bubble_cnt <= 64'd0;
        end else begin
            if (i_fetch)  r_fetch_cnt  <= r_fetch_cnt + 64'd1;
            if (i_bubble) r_bubble_cnt <= r_bubble_cnt + 64'd1;
        end
    end

    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: rtl/ifu_fetch_unit_ysyx23060136.sv
// IF front end: PC generation, valid/ready imem fetch, one-entry instruction buffer; IFU_PERF_EN adds perf counters.
// Instruction visible the cycle after its response; request held until ready, output held while FORWARD_stallID.
module ifu_fetch_unit_ysyx23060136
    import ifu_pkg_ysyx23060136::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        BRANCH_flushIF,
    input  logic [31:0] BRANCH_target,
    input  logic        FORWARD_stallID,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        IFU_o_valid,
    output logic [31:0] IFU_o_pc,
    output logic [31:0] IFU_o_inst
`ifdef IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_bubble_cnt
`endif
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;
    logic        r_drop;
    logic        w_drop_nxt;
    logic        w_load_buf;
    logic        w_consume;
    logic        w_redirect;
    logic        w_req_fire;

    // Same qualification the IF/ID segment register applies.
    assign w_consume  = IFU_o_valid & ~FORWARD_stallID;
    assign w_redirect = BRANCH_flushIF & ~FORWARD_stallID;
    assign w_req_fire = imem_req_valid & imem_req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_load_buf  = 1'b0;
        case (r_state)
            REQ: begin
                w_drop_nxt = 1'b0;
                if (w_redirect) begin
                    w_pc_nxt = align_pc(BRANCH_target);
                    if (w_req_fire) begin
                        w_state_nxt = DROP;
                        w_drop_nxt  = 1'b1;
                    end
                end else if (w_req_fire) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_redirect) begin
                    w_pc_nxt = align_pc(BRANCH_target);
                    // A stale response landing this very cycle is already gone; nothing left to drop.
                    if (imem_rsp_valid) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = DROP;
                        w_drop_nxt  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    w_state_nxt = HOLD;
                    w_load_buf  = 1'b1;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = align_pc(BRANCH_target);
                    w_state_nxt = REQ;
                end else if (w_consume) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                if (w_redirect) w_pc_nxt = align_pc(BRANCH_target);
                if (imem_rsp_valid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= RST_PC;
            r_drop     <= (r_state == WAIT);
            r_buf_pc   <= RST_PC;
            r_buf_inst <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_load_buf) begin
                r_buf_pc   <= r_pc;
                r_buf_inst <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = (r_state == REQ) & ~rst;
    assign imem_req_addr  = align_pc(r_pc);
    assign IFU_o_valid    = (r_state == HOLD) & ~rst;
    assign IFU_o_pc       = IFU_o_valid ? r_buf_pc   : RST_PC;
    assign IFU_o_inst     = IFU_o_valid ? r_buf_inst : NOP_INST;

`ifdef IFU_PERF_EN
    logic w_bubble;
    assign w_bubble = ~FORWARD_stallID & ~IFU_o_valid;

    ifu_perf_cnt_ysyx23060136 u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_fetch     (w_consume),
        .i_bubble    (w_bubble),
        .o_fetch_cnt (perf_fetch_cnt),
        .o_bubble_cnt(perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch_unit_ysyx23060136.sv
// Bench for the fetch unit: memory model with programmable ready/response delay and an in-order scoreboard.
module tb_ifu_fetch_unit_ysyx23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        BRANCH_flushIF;
    logic [31:0] BRANCH_target;
    logic        FORWARD_stallID;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        IFU_o_valid;
    logic [31:0] IFU_o_pc;
    logic [31:0] IFU_o_inst;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_low_until = 0;
    int rsp_lat = 0;
    logic [31:0] exp_q[$];
    int          cons_cyc[$];
    logic [31:0] acc_log[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifu_fetch_unit_ysyx23060136 dut (
        .clk            (clk),
        .rst            (rst),
        .BRANCH_flushIF (BRANCH_flushIF),
        .BRANCH_target  (BRANCH_target),
        .FORWARD_stallID(FORWARD_stallID),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IFU_o_valid    (IFU_o_valid),
        .IFU_o_pc       (IFU_o_pc),
        .IFU_o_inst     (IFU_o_inst)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: ready low while cyc < rdy_low_until; response rsp_lat cycles after the accept cycle.
    initial begin : mem_model
        logic        acc;
        logic        was_rst;
        logic [31:0] a;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            acc     = imem_req_valid && imem_req_ready;
            a       = imem_req_addr;
            was_rst = rst;
            @(posedge clk);
            #1;
            if (was_rst) acc_log.delete();
            if (acc) begin
                acc_log.push_back(a);
                pend_addr.push_back(a);
                pend_due.push_back(cyc + rsp_lat);
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            imem_req_ready = (cyc >= rdy_low_until);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input int rdy_delay, output int rel);
        rst            = 1'b1;
        BRANCH_flushIF = 1'b0;
        step(1);
        rdy_low_until = cyc + 1 + rdy_delay;
        step(1);
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic drain(input int bound, output bit ok);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            step(1);
            k++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // Scoreboard: every consume not squashed by a same-cycle redirect must match the next expected PC.
    task automatic run_scoreboard();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && IFU_o_valid && !FORWARD_stallID && !BRANCH_flushIF) begin
                cons_cyc.push_back(cyc);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: consumed pc=%h inst=%h, none expected", IFU_o_pc, IFU_o_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (IFU_o_pc !== e || IFU_o_inst !== inst_of(e)) begin
                        n_fail++;
                        $display("FAIL sb_consume: got pc=%h inst=%h, expected pc=%h inst=%h",
                                 IFU_o_pc, IFU_o_inst, e, inst_of(e));
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        int rel;
        rst = 1'b1; BRANCH_flushIF = 1'b0; BRANCH_target = 32'h0; FORWARD_stallID = 1'b1;
        step(1);
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b0 || IFU_o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids: req_valid=%b o_valid=%b, expected 0 0", imem_req_valid, IFU_o_valid);
        end
        n_tests++;
        if (IFU_o_pc !== 32'h8000_0000 || IFU_o_inst !== 32'h0000_0013) begin
            n_fail++; $display("FAIL reset_outputs: pc=%h inst=%h, expected 80000000 00000013", IFU_o_pc, IFU_o_inst);
        end
        reset_dut(0, rel);
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            n_fail++; $display("FAIL reset_first_req: valid=%b addr=%h, expected 1 80000000", imem_req_valid, imem_req_addr);
        end
        step(8);
    endtask

    task automatic test_zero_wait();
        int rel;
        bit ok;
        rsp_lat = 0;
        reset_dut(0, rel);
        FORWARD_stallID = 1'b0;
        cons_cyc.delete();
        exp_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL zw_drain: %0d instructions still expected, required 0", exp_q.size()); end
        n_tests++;
        if (acc_log.size() < 3 || acc_log[0] !== 32'h8000_0000 || acc_log[1] !== 32'h8000_0004 || acc_log[2] !== 32'h8000_0008) begin
            n_fail++; $display("FAIL zw_req_addrs: %0d requests logged, first=%h, expected 80000000/04/08", acc_log.size(), acc_log[0]);
        end
        n_tests++;
        if (cons_cyc.size() < 3 || cons_cyc[0] !== rel + 2) begin
            n_fail++; $display("FAIL zw_latency: first consume at cycle %0d, expected %0d", cons_cyc[0], rel + 2);
        end
        n_tests++;
        if (cons_cyc.size() < 3 || cons_cyc[2] - cons_cyc[0] !== 6) begin
            n_fail++; $display("FAIL zw_throughput: 3 instrs over %0d cycles, expected 6", cons_cyc[2] - cons_cyc[0]);
        end
        step(8);
    endtask

    task automatic test_req_stall();
        int rel;
        bit ok;
        rsp_lat = 0;
        reset_dut(3, rel);
        FORWARD_stallID = 1'b0;
        cons_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || IFU_o_valid !== 1'b0) begin
                n_fail++; $display("FAIL rs_hold_%0d: req_valid=%b addr=%h o_valid=%b, expected 1 80000000 0",
                                   i, imem_req_valid, imem_req_addr, IFU_o_valid);
            end
            step(1);
        end
        exp_q = '{32'h8000_0000};
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok || cons_cyc.size() < 1 || cons_cyc[0] !== rel + 5) begin
            n_fail++; $display("FAIL rs_present: drained=%b consume cycle %0d, expected 1 %0d", ok, cons_cyc[0], rel + 5);
        end
        step(8);
    endtask

    task automatic test_stall_hold();
        int rel;
        bit ok;
        rsp_lat = 0;
        reset_dut(0, rel);
        FORWARD_stallID = 1'b1;
        exp_q = '{32'h8000_0000, 32'h8000_0004};
        step(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (IFU_o_valid !== 1'b1 || IFU_o_pc !== 32'h8000_0000 || IFU_o_inst !== inst_of(32'h8000_0000) || imem_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL sh_hold_%0d: valid=%b pc=%h inst=%h req=%b, expected 1 80000000 %h 0",
                                   i, IFU_o_valid, IFU_o_pc, IFU_o_inst, imem_req_valid, inst_of(32'h8000_0000));
            end
            step(1);
        end
        FORWARD_stallID = 1'b0;
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL sh_resume: %0d instructions still expected, required 0", exp_q.size()); end
        step(8);
    endtask

    task automatic test_flush_wait();
        int rel;
        bit ok;
        rsp_lat = 1;
        reset_dut(0, rel);
        FORWARD_stallID = 1'b0;
        exp_q = '{32'h8000_0100};
        step(1);
        BRANCH_flushIF = 1'b1;
        BRANCH_target  = 32'h8000_0102;
        step(1);
        BRANCH_flushIF = 1'b0;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b0 || IFU_o_valid !== 1'b0) begin
            n_fail++; $display("FAIL fw_drop: req_valid=%b o_valid=%b, expected 0 0", imem_req_valid, IFU_o_valid);
        end
        step(1);
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_fail++; $display("FAIL fw_new_req: valid=%b addr=%h, expected 1 80000100", imem_req_valid, imem_req_addr);
        end
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL fw_drain: %0d instructions still expected, required 0", exp_q.size()); end
        step(8);
        rsp_lat = 0;
    endtask

    task automatic test_flush_stall();
        int rel;
        bit ok;
        rsp_lat = 0;
        reset_dut(0, rel);
        FORWARD_stallID = 1'b1;
        exp_q = '{32'h9000_0010};
        step(3);
        BRANCH_flushIF = 1'b1;
        BRANCH_target  = 32'h9000_0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (IFU_o_valid !== 1'b1 || IFU_o_pc !== 32'h8000_0000 || imem_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL fs_ignored_%0d: valid=%b pc=%h req=%b, expected 1 80000000 0",
                                   i, IFU_o_valid, IFU_o_pc, imem_req_valid);
            end
            step(1);
        end
        FORWARD_stallID = 1'b0;
        step(1);
        BRANCH_flushIF = 1'b0;
        @(negedge clk);
        n_tests++;
        if (IFU_o_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h9000_0010) begin
            n_fail++; $display("FAIL fs_honoured: o_valid=%b req=%b addr=%h, expected 0 1 90000010",
                               IFU_o_valid, imem_req_valid, imem_req_addr);
        end
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL fs_drain: %0d instructions still expected, required 0", exp_q.size()); end
        step(8);
    endtask

    task automatic test_wrap();
        int rel;
        bit ok;
        rsp_lat = 0;
        reset_dut(2, rel);
        FORWARD_stallID = 1'b0;
        BRANCH_flushIF  = 1'b1;
        BRANCH_target   = 32'hFFFF_FFFF;
        step(1);
        BRANCH_flushIF = 1'b0;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wr_target: valid=%b addr=%h, expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wr_drain: %0d instructions still expected, required 0", exp_q.size()); end
        n_tests++;
        if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wr_addrs: %0d requests, got %h %h, expected fffffffc 00000000", acc_log.size(), acc_log[0], acc_log[1]);
        end
        step(4);
`ifdef IFU_PERF_EN
        n_tests++;
        if (perf_fetch_cnt !== 64'd2) begin
            n_fail++; $display("FAIL perf_fetch: got %0d, expected 2", perf_fetch_cnt);
        end
        n_tests++;
        if (perf_bubble_cnt !== 64'd6) begin
            n_fail++; $display("FAIL perf_bubble: got %0d, expected 6", perf_bubble_cnt);
        end
`endif
        step(4);
    endtask

    task automatic test_reset_mid();
        int rel;
        bit ok;
        rsp_lat = 2;
        reset_dut(0, rel);
        FORWARD_stallID = 1'b0;
        cons_cyc.delete();
        step(2);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b0 || IFU_o_valid !== 1'b0 || IFU_o_pc !== 32'h8000_0000 || IFU_o_inst !== 32'h0000_0013) begin
            n_fail++; $display("FAIL rm_reset_outs: req=%b valid=%b pc=%h inst=%h, expected 0 0 80000000 00000013",
                               imem_req_valid, IFU_o_valid, IFU_o_pc, IFU_o_inst);
        end
        step(1);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || IFU_o_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_restart: req=%b addr=%h valid=%b, expected 1 80000000 0",
                               imem_req_valid, imem_req_addr, IFU_o_valid);
        end
        exp_q = '{32'h8000_0000};
        drain(40, ok);
        FORWARD_stallID = 1'b1;
        step(8);
        n_tests++;
        if (!ok || cons_cyc.size() !== 1) begin
            n_fail++; $display("FAIL rm_once: drained=%b consumes=%0d, expected 1 1", ok, cons_cyc.size());
        end
        rsp_lat = 0;
    endtask

    initial begin
        rst = 1'b1;
        BRANCH_flushIF  = 1'b0;
        BRANCH_target   = 32'h0;
        FORWARD_stallID = 1'b1;
        fork
            run_scoreboard();
        join_none
        test_reset();
        test_zero_wait();
        test_req_stall();
        test_stall_hold();
        test_flush_wait();
        test_flush_stall();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
